// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe game controller slice:
//   state_t    - controller FSM states
//   PLAYER_*   - player codes carried on turn (X = 0, O = 1)
//   RES_*      - result codes, same encoding as the board's game_state
//   cell_idx() - maps a 1-based row/col pair to a 0..8 cell index, or
//                CELL_INV when either coordinate is 0
// ---------------------------------------------------------------------------
package ttt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_MOVE,
    S_COMMIT,
    S_SETTLE1,
    S_SETTLE2,
    S_OVER
  } state_t;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [3:0] CELL_INV = 4'hF;

  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd0 || col == 2'd0) return CELL_INV;
    return 4'(row - 2'd1) * 4'd3 + 4'(col - 2'd1);
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl_if
// Bundles the player move handshake and the board bus seen by the game
// controller.
//   start          - new-game pulse
//   mv_req/row/col - per-player move request lanes (player p in [2p+1:2p])
//   mv_ack/nack    - per-player accept / reject pulses
//   brd_set/reset/row/col           - commands to the board
//   brd_valid/symbol/game_state     - board status back to the controller
// Modports: master = controller side, slave = players + board side.
// ---------------------------------------------------------------------------
interface ttt_game_ctrl_if;
  logic       start;
  logic [1:0] mv_req;
  logic [3:0] mv_row;
  logic [3:0] mv_col;
  logic [1:0] mv_ack;
  logic [1:0] mv_nack;
  logic       brd_set;
  logic       brd_reset;
  logic [1:0] brd_row;
  logic [1:0] brd_col;
  logic [8:0] brd_valid;
  logic [8:0] brd_symbol;
  logic [1:0] brd_game_state;

  modport master (
    input  start, mv_req, mv_row, mv_col, brd_valid, brd_symbol, brd_game_state,
    output mv_ack, mv_nack, brd_set, brd_reset, brd_row, brd_col
  );

  modport slave (
    output start, mv_req, mv_row, mv_col, brd_valid, brd_symbol, brd_game_state,
    input  mv_ack, mv_nack, brd_set, brd_reset, brd_row, brd_col
  );
endinterface

// File: rtl/ttt_move_timer.sv
// ---------------------------------------------------------------------------
// ttt_move_timer
// Counts cycles spent waiting for a move. expired is high during the
// TIMEOUT_CYCLES-th enabled cycle after a clear, so the controller can still
// let a legal move in that same cycle win over the forfeit.
//   clk, reset - clock, asynchronous active-high reset
//   clear      - restart the count at zero
//   enable     - count this cycle
//   expired    - this enabled cycle is the last one allowed
// TIMEOUT_CYCLES = 0 disables expiry.
// ---------------------------------------------------------------------------
module ttt_move_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + TMR_W'(1);
  end

  // cnt holds the number of earlier enabled cycles, so LAST marks the Nth one.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
// Turn sequencer and move arbiter for the 3x3 tic-tac-toe board. Accepts
// legal moves from the player whose turn it is, commits them to the board,
// waits for the board's registered game_state and declares the result.
// A per-move timeout forfeits the game for the waiting player.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - move handshake and board bus (ttt_game_ctrl_if.master)
//   turn       - player to move (0 = X, 1 = O)
//   busy       - game in progress (not IDLE / OVER)
//   result     - 00 none, 01 X, 10 O, 11 draw
//   forfeit    - game ended by timeout
//   err        - sticky: the board failed to record a committed move
//   moves      - moves committed this game
// ---------------------------------------------------------------------------
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  ttt_game_ctrl_if.master   bus,
  output logic              turn,
  output logic              busy,
  output logic [1:0]        result,
  output logic              forfeit,
  output logic              err,
  output logic [3:0]        moves
);

  state_t     state, state_nxt;
  logic [1:0] req_row, req_col;
  logic [3:0] req_idx, set_idx;
  logic       req_legal, rec_ok;
  logic       accept, timeout, tmr_expired;

  // Only the lane of the player to move is ever looked at.
  assign req_row   = bus.mv_row[{turn, 1'b0} +: 2];
  assign req_col   = bus.mv_col[{turn, 1'b0} +: 2];
  assign req_idx   = cell_idx(req_row, req_col);
  assign req_legal = (req_idx != CELL_INV) && !bus.brd_valid[req_idx];

  // The board tracks its own symbol alternation; X must land as 1, O as 0.
  assign set_idx = cell_idx(bus.brd_row, bus.brd_col);
  assign rec_ok  = (set_idx != CELL_INV) && bus.brd_valid[set_idx] &&
                   (bus.brd_symbol[set_idx] == (turn == PLAYER_X));

  assign bus.brd_set   = (state == S_COMMIT);
  assign bus.brd_reset = (state == S_CLEAR);
  assign busy          = (state != S_IDLE) && (state != S_OVER);

  ttt_move_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != S_WAIT_MOVE),
    .enable  (state == S_WAIT_MOVE),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // start overrides everything, including a same-cycle move request.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    timeout     = 1'b0;
    bus.mv_ack  = 2'b00;
    bus.mv_nack = 2'b00;
    if (bus.start) begin
      state_nxt = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_IDLE;
        S_CLEAR:   state_nxt = S_WAIT_MOVE;
        S_WAIT_MOVE: begin
          if (bus.mv_req[turn] && req_legal) begin
            accept           = 1'b1;
            bus.mv_ack[turn] = 1'b1;
            state_nxt        = S_COMMIT;
          end else begin
            if (bus.mv_req[turn]) bus.mv_nack[turn] = 1'b1;
            if (tmr_expired) begin
              timeout   = 1'b1;
              state_nxt = S_OVER;
            end
          end
        end
        S_COMMIT:  state_nxt = S_SETTLE1;
        S_SETTLE1: state_nxt = S_SETTLE2;
        S_SETTLE2: state_nxt = (bus.brd_game_state != RES_NONE) ? S_OVER : S_WAIT_MOVE;
        S_OVER:    state_nxt = S_OVER;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turn        <= PLAYER_X;
      result      <= RES_NONE;
      forfeit     <= 1'b0;
      err         <= 1'b0;
      moves       <= 4'd0;
      bus.brd_row <= 2'd0;
      bus.brd_col <= 2'd0;
    end else begin
      if (state == S_CLEAR) begin
        turn    <= PLAYER_X;
        result  <= RES_NONE;
        forfeit <= 1'b0;
        err     <= 1'b0;
        moves   <= 4'd0;
      end
      if (accept) begin
        bus.brd_row <= req_row;
        bus.brd_col <= req_col;
      end
      if (state == S_COMMIT) moves <= moves + 4'd1;
      if (timeout) begin
        forfeit <= 1'b1;
        result  <= (turn == PLAYER_X) ? RES_O : RES_X;
      end
      if (state == S_SETTLE2 && !bus.start) begin
        if (!rec_ok) err <= 1'b1;
        if (bus.brd_game_state != RES_NONE) result <= bus.brd_game_state;
        else turn <= (turn == PLAYER_X) ? PLAYER_O : PLAYER_X;
      end
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_game_ctrl
// Directed bench for ttt_game_ctrl with a behavioural 3x3 board: the board
// alternates X/O symbols itself, updates a cell on set and registers its
// game_state one cycle after the cell becomes visible. drop_set makes the
// board ignore a set while still advancing its symbol.
// ---------------------------------------------------------------------------
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       turn, busy, forfeit, err;
  logic [1:0] result;
  logic [3:0] moves;

  int passed  = 0;
  int total   = 0;
  int set_cnt = 0;

  logic       drop_set = 1'b0;
  logic [8:0] cell_v   = '0;
  logic [8:0] cell_s   = '0;
  logic [1:0] gs       = RES_NONE;
  logic       bsym     = 1'b1;
  int         bidx;

  logic [8:0] lines [8] = '{9'b000000111, 9'b000111000, 9'b111000000,
                            9'b001001001, 9'b010010010, 9'b100100100,
                            9'b100010001, 9'b001010100};

  ttt_game_ctrl_if bus();

  assign bus.brd_valid      = cell_v;
  assign bus.brd_symbol     = cell_s;
  assign bus.brd_game_state = gs;

  ttt_game_ctrl #(.TIMEOUT_CYCLES(8), .TMR_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .turn    (turn),
    .busy    (busy),
    .result  (result),
    .forfeit (forfeit),
    .err     (err),
    .moves   (moves)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] judge(input logic [8:0] v, input logic [8:0] s);
    logic [8:0] xs, os;
    xs = v & s;
    os = v & ~s;
    for (int i = 0; i < 8; i++) begin
      if ((xs & lines[i]) == lines[i]) return RES_X;
      if ((os & lines[i]) == lines[i]) return RES_O;
    end
    if (&v) return RES_DRAW;
    return RES_NONE;
  endfunction

  always_comb bidx = (int'(bus.brd_row) - 1) * 3 + int'(bus.brd_col) - 1;

  always @(posedge clk) begin
    if (bus.brd_reset) begin
      cell_v <= '0;
      cell_s <= '0;
      gs     <= RES_NONE;
      bsym   <= 1'b1;
    end else begin
      if (bus.brd_set) begin
        if (!drop_set) begin
          cell_v[bidx] <= 1'b1;
          cell_s[bidx] <= bsym;
        end
        bsym    <= ~bsym;
        set_cnt <= set_cnt + 1;
      end
      gs <= judge(cell_v, cell_s);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("clear_brd_reset", 32'(bus.brd_reset), 32'd1);
    tick();
    chk("wait_brd_reset_low", 32'(bus.brd_reset), 32'd0);
  endtask

  // Present a legal move in WAIT_MOVE; returns in the cycle after SETTLE2.
  task automatic play(input logic p, input logic [1:0] r, input logic [1:0] c);
    bus.mv_req = p ? 2'b10 : 2'b01;
    bus.mv_row = p ? {r, 2'b00} : {2'b00, r};
    bus.mv_col = p ? {c, 2'b00} : {2'b00, c};
    #1;
    chk("mv_ack", 32'(bus.mv_ack), p ? 32'd2 : 32'd1);
    chk("mv_nack_on_ack", 32'(bus.mv_nack), 32'd0);
    tick();
    bus.mv_req = 2'b00;
    chk("brd_set", 32'(bus.brd_set), 32'd1);
    chk("brd_row", 32'(bus.brd_row), 32'(r));
    chk("brd_col", 32'(bus.brd_col), 32'(c));
    tick();
    chk("brd_set_1cyc", 32'(bus.brd_set), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mv_req = 2'b00;
    bus.mv_row = 4'd0;
    bus.mv_col = 4'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_moves", 32'(moves), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_brd_set", 32'(bus.brd_set), 32'd0);
    chk("rst_brd_reset", 32'(bus.brd_reset), 32'd0);
    chk("rst_brd_row", 32'(bus.brd_row), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // X wins along row 1 on the 5th move.
    start_game();
    chk("g1_turn0", 32'(turn), 32'd0);
    chk("g1_busy", 32'(busy), 32'd1);
    play(1'b0, 2'd1, 2'd1);
    chk("g1_turn1", 32'(turn), 32'd1);
    play(1'b1, 2'd2, 2'd1);
    play(1'b0, 2'd1, 2'd2);
    play(1'b1, 2'd2, 2'd2);
    play(1'b0, 2'd1, 2'd3);
    chk("g1_result", 32'(result), 32'(RES_X));
    chk("g1_moves", 32'(moves), 32'd5);
    chk("g1_busy_over", 32'(busy), 32'd0);
    chk("g1_forfeit", 32'(forfeit), 32'd0);
    chk("g1_err", 32'(err), 32'd0);
    chk("g1_set_cnt", 32'(set_cnt), 32'd5);
    bus.mv_req = 2'b10;
    bus.mv_row = 4'b1100;
    bus.mv_col = 4'b1100;
    #1;
    chk("over_no_ack", 32'(bus.mv_ack), 32'd0);
    chk("over_no_nack", 32'(bus.mv_nack), 32'd0);
    tick();
    bus.mv_req = 2'b00;
    chk("over_hold_result", 32'(result), 32'(RES_X));

    // Illegal requests and out-of-turn requests.
    start_game();
    chk("g2_result_cleared", 32'(result), 32'd0);
    play(1'b0, 2'd1, 2'd1);
    bus.mv_req = 2'b10;
    bus.mv_row = 4'b0100;
    bus.mv_col = 4'b0100;
    #1;
    chk("occupied_nack", 32'(bus.mv_nack), 32'd2);
    chk("occupied_no_ack", 32'(bus.mv_ack), 32'd0);
    tick();
    chk("occupied_turn", 32'(turn), 32'd1);
    bus.mv_row = 4'b0000;
    bus.mv_col = 4'b0100;
    #1;
    chk("row0_nack", 32'(bus.mv_nack), 32'd2);
    tick();
    bus.mv_req = 2'b00;
    play(1'b1, 2'd2, 2'd2);
    chk("g2_turn_x", 32'(turn), 32'd0);
    bus.mv_req = 2'b10;
    bus.mv_row = 4'b1100;
    bus.mv_col = 4'b1100;
    #1;
    chk("oot_no_ack", 32'(bus.mv_ack), 32'd0);
    chk("oot_no_nack", 32'(bus.mv_nack), 32'd0);
    tick();
    bus.mv_req = 2'b00;
    chk("oot_turn", 32'(turn), 32'd0);
    chk("g2_moves", 32'(moves), 32'd2);

    // Full board with no line: draw.
    start_game();
    play(1'b0, 2'd1, 2'd1);
    play(1'b1, 2'd1, 2'd2);
    play(1'b0, 2'd1, 2'd3);
    play(1'b1, 2'd2, 2'd2);
    play(1'b0, 2'd2, 2'd1);
    play(1'b1, 2'd2, 2'd3);
    play(1'b0, 2'd3, 2'd2);
    play(1'b1, 2'd3, 2'd1);
    chk("draw_not_yet", 32'(result), 32'd0);
    play(1'b0, 2'd3, 2'd3);
    chk("draw_result", 32'(result), 32'(RES_DRAW));
    chk("draw_moves", 32'(moves), 32'd9);
    chk("draw_busy", 32'(busy), 32'd0);

    // X never moves: forfeit after 8 WAIT_MOVE cycles.
    start_game();
    repeat (7) tick();
    chk("to_8th_busy", 32'(busy), 32'd1);
    chk("to_8th_forfeit", 32'(forfeit), 32'd0);
    tick();
    chk("to_forfeit", 32'(forfeit), 32'd1);
    chk("to_result", 32'(result), 32'(RES_O));
    chk("to_busy", 32'(busy), 32'd0);

    // Legal request in the expiry cycle wins.
    start_game();
    repeat (7) tick();
    play(1'b0, 2'd2, 2'd2);
    chk("exp_no_forfeit", 32'(forfeit), 32'd0);
    chk("exp_turn", 32'(turn), 32'd1);
    chk("exp_busy", 32'(busy), 32'd1);

    // start during SETTLE1 aborts the game.
    bus.mv_req = 2'b10;
    bus.mv_row = 4'b0100;
    bus.mv_col = 4'b0100;
    #1;
    chk("abort_ack", 32'(bus.mv_ack), 32'd2);
    tick();
    bus.mv_req = 2'b00;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("abort_brd_reset", 32'(bus.brd_reset), 32'd1);
    tick();
    chk("abort_moves", 32'(moves), 32'd0);
    chk("abort_turn", 32'(turn), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_board_clear", 32'(cell_v), 32'd0);

    // Asynchronous reset during COMMIT.
    bus.mv_req = 2'b01;
    bus.mv_row = 4'b0001;
    bus.mv_col = 4'b0001;
    #1;
    chk("ar_ack", 32'(bus.mv_ack), 32'd1);
    tick();
    bus.mv_req = 2'b00;
    chk("ar_commit_set", 32'(bus.brd_set), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_set_low", 32'(bus.brd_set), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_brd_row", 32'(bus.brd_row), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_idle", 32'(busy), 32'd0);

    // Board drops a set: err latches, turn still toggles, CLEAR clears err.
    start_game();
    drop_set = 1'b1;
    play(1'b0, 2'd1, 2'd1);
    drop_set = 1'b0;
    chk("drop_err", 32'(err), 32'd1);
    chk("drop_turn", 32'(turn), 32'd1);
    chk("drop_busy", 32'(busy), 32'd1);
    start_game();
    chk("drop_err_cleared", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
